// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: one shared W-bit adder serving NREQ requesters.
// A round-robin arbiter picks one valid request per cycle. The chosen operands
// are added and the sum lands in a one-entry result slot, tagged with the
// requester index. busy_cnt counts cycles in which requests wait on a full slot.
//
// Slot FSM
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_EMPTY | no result held, rsp_valid=0, any granted request is accepted
//   S_FULL  | result held, rsp_valid=1; refilled only when rsp_ready is high
module adder_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic                         clk,
   input  logic                         areset,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*W-1:0]            req_x,
   input  logic [NREQ*W-1:0]            req_y,
   output logic [NREQ-1:0]              req_ready,
   output logic                         rsp_valid,
   output logic [$clog2(NREQ)-1:0]      rsp_id,
   output logic [W:0]                   rsp_sum,
   input  logic                         rsp_ready,
   output logic [7:0]                   busy_cnt
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_t;

   slot_t            r_state;
   slot_t            w_state_nxt;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   w_rr_ptr_nxt;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   w_id_nxt;
   logic [W:0]       r_sum;
   logic [W:0]       w_sum_nxt;
   logic [7:0]       r_busy;

   logic [NREQ-1:0]  w_ptr_mask;
   logic [NREQ-1:0]  w_hi_req;
   logic [NREQ-1:0]  w_pick_src;
   logic [NREQ-1:0]  w_gnt_onehot;
   logic [IDW-1:0]   w_gnt_id;
   logic             w_any_req;
   logic             w_can_accept;
   logic             w_xfer;
   logic [W-1:0]     w_op_x;
   logic [W-1:0]     w_op_y;
   logic [W:0]       w_sum;

   assign rsp_valid = (r_state == S_FULL);
   assign rsp_id    = r_id;
   assign rsp_sum   = r_sum;
   assign busy_cnt  = r_busy;

   assign w_any_req    = |req_valid;
   assign w_can_accept = !rsp_valid || rsp_ready;
   assign w_xfer       = w_any_req && w_can_accept;

   // Mask of requester indices at or above the round-robin pointer.
   always_comb begin
      w_ptr_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_ptr_mask[i] = (IDW'(i) >= r_rr_ptr);
      end
   end

   // Prefer requests at/after the pointer; if none, wrap to the full request set.
   assign w_hi_req     = req_valid & w_ptr_mask;
   assign w_pick_src   = (|w_hi_req) ? w_hi_req : req_valid;
   assign w_gnt_onehot = w_pick_src & (~w_pick_src + NREQ'(1));

   // Encode the one-hot grant into an index and steer that requester's operands.
   always_comb begin
      w_gnt_id = '0;
      w_op_x   = '0;
      w_op_y   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_onehot[i]) begin
            w_gnt_id = IDW'(i);
            w_op_x   = req_x[i*W +: W];
            w_op_y   = req_y[i*W +: W];
         end
      end
   end

   assign w_sum = {1'b0, w_op_x} + {1'b0, w_op_y};

   // Ready goes only to the granted requester, and never while reset is held.
   assign req_ready = (w_xfer && !areset) ? w_gnt_onehot : '0;

   // Slot state, tag, sum and round-robin pointer registers.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state  <= S_EMPTY;
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_sum    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_id     <= w_id_nxt;
         r_sum    <= w_sum_nxt;
      end
   end

   // Next-state logic: load on accept, drain on consume, otherwise hold.
   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_id_nxt     = r_id;
      w_sum_nxt    = r_sum;
      case (r_state)
         S_EMPTY: begin
            if (w_xfer) begin
               w_state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            if (w_xfer) begin
               w_state_nxt = S_FULL;
            end else if (rsp_ready) begin
               w_state_nxt = S_EMPTY;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      if (w_xfer) begin
         w_id_nxt     = w_gnt_id;
         w_sum_nxt    = w_sum;
         w_rr_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
      end
   end

   // Saturating count of cycles where some request is blocked by a full slot.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_busy <= '0;
      end else if (w_any_req && !w_can_accept && (r_busy != 8'hFF)) begin
         r_busy <= r_busy + 8'd1;
      end
   end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter (NREQ=4, W=4): directed vector table, hand-written
// stall/wrap/reset/saturation sequences, and randomized traffic against a
// behavioural model with a per-requester scoreboard.
module tb_adder_rr_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;

   logic         clk = 1'b0;
   logic         areset;
   logic [3:0]   req_valid;
   logic [15:0]  req_x;
   logic [15:0]  req_y;
   logic [3:0]   req_ready;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic [4:0]   rsp_sum;
   logic         rsp_ready;
   logic [7:0]   busy_cnt;

   int n_checks = 0;
   int n_err    = 0;

   adder_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .areset    (areset),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ready (rsp_ready),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [15:0] x;
      logic [15:0] y;
      logic        rr;
      logic [3:0]  e_ready;
      logic        e_valid;
      logic [1:0]  e_id;
      logic [4:0]  e_sum;
      logic [7:0]  e_busy;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Round-robin choice straight from the rule: first valid index starting at ptr.
   function automatic int rr_pick(input logic [3:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int idx = (ptr + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic do_reset();
      areset    = 1'b1;
      req_valid = 4'b1111;
      req_x     = 16'hFFFF;
      req_y     = 16'hFFFF;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_sum",   rsp_sum,   0);
      check("rst_rsp_id",    rsp_id,    0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy",      busy_cnt,  0);
      req_valid = '0;
      req_x     = '0;
      req_y     = '0;
      @(posedge clk);
      #1;
      areset = 1'b0;
   endtask

   // Random-phase state
   logic [4:0] sb [4][$];
   int         m_ptr;
   logic       m_valid;
   int         m_id;
   logic [4:0] m_sum;
   int         m_busy;
   logic [3:0] pv;
   logic [3:0] px [4];
   logic [3:0] py [4];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      areset    = 1'b1;
      req_valid = '0;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = 1'b0;

      tbl[0] = '{4'b0100, 16'h0F00, 16'h0100, 1'b1, 4'b0100, 1'b0, 2'd0, 5'h00, 8'd0};
      tbl[1] = '{4'b1001, 16'h7003, 16'h9004, 1'b1, 4'b1000, 1'b1, 2'd2, 5'h10, 8'd0};
      tbl[2] = '{4'b1001, 16'h1003, 16'h1004, 1'b1, 4'b0001, 1'b1, 2'd3, 5'h10, 8'd0};
      tbl[3] = '{4'b1000, 16'h1000, 16'h1000, 1'b1, 4'b1000, 1'b1, 2'd0, 5'h07, 8'd0};
      tbl[4] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd3, 5'h02, 8'd0};
      tbl[5] = '{4'b0010, 16'h00A0, 16'h00B0, 1'b0, 4'b0000, 1'b1, 2'd3, 5'h02, 8'd0};
      tbl[6] = '{4'b0010, 16'h00A0, 16'h00B0, 1'b1, 4'b0010, 1'b1, 2'd3, 5'h02, 8'd1};
      tbl[7] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 2'd1, 5'h15, 8'd1};
      tbl[8] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0, 5'h00, 8'd1};

      // Directed table: single request, wrap from 3 to 0, stall and resume.
      do_reset();
      for (int k = 0; k < 9; k++) begin
         req_valid = tbl[k].v;
         req_x     = tbl[k].x;
         req_y     = tbl[k].y;
         rsp_ready = tbl[k].rr;
         @(negedge clk);
         check($sformatf("tbl%0d_ready", k), req_ready, tbl[k].e_ready);
         check($sformatf("tbl%0d_valid", k), rsp_valid, tbl[k].e_valid);
         if (tbl[k].e_valid) begin
            check($sformatf("tbl%0d_id", k),  rsp_id,  tbl[k].e_id);
            check($sformatf("tbl%0d_sum", k), rsp_sum, tbl[k].e_sum);
         end
         check($sformatf("tbl%0d_busy", k), busy_cnt, tbl[k].e_busy);
         @(posedge clk);
         #1;
      end

      // All four valid every cycle: one result per cycle in order 0,1,2,3,0,1.
      do_reset();
      req_valid = 4'b1111;
      req_x     = {4'd3, 4'd2, 4'd1, 4'd0};
      req_y     = {4'd3, 4'd2, 4'd1, 4'd0};
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rr_first_ready", req_ready, 4'b0001);
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check($sformatf("rr%0d_valid", n), rsp_valid, 1);
         check($sformatf("rr%0d_id", n),    rsp_id,    n % 4);
         check($sformatf("rr%0d_sum", n),   rsp_sum,   2 * (n % 4));
      end

      // Hold a result for 3 cycles, then consume and accept on the same edge.
      do_reset();
      req_valid = 4'b0010;
      req_x     = 16'h0050;
      req_y     = 16'h0060;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("hold_first_ready", req_ready, 4'b0010);
      @(posedge clk);
      #1;
      req_x = 16'h0020;
      req_y = 16'h0030;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check($sformatf("hold%0d_ready", s), req_ready, 4'b0000);
         check($sformatf("hold%0d_valid", s), rsp_valid, 1);
         check($sformatf("hold%0d_id", s),    rsp_id,    1);
         check($sformatf("hold%0d_sum", s),   rsp_sum,   5'h0B);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("hold_busy3",     busy_cnt,  3);
      check("hold_rel_ready", req_ready, 4'b0010);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_new_valid", rsp_valid, 1);
      check("hold_new_id",    rsp_id,    1);
      check("hold_new_sum",   rsp_sum,   5'h05);
      check("hold_new_busy",  busy_cnt,  3);

      // Asynchronous reset in the middle of a stall.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midrst_pre_ready", req_ready, 4'b0000);
      check("midrst_pre_valid", rsp_valid, 1);
      #1;
      areset = 1'b1;
      #1;
      check("midrst_valid", rsp_valid, 0);
      check("midrst_ready", req_ready, 4'b0000);
      check("midrst_busy",  busy_cnt,  0);
      check("midrst_sum",   rsp_sum,   0);
      req_valid = '0;
      @(posedge clk);
      #1;
      areset = 1'b0;

      // Stall counter saturation at 255.
      do_reset();
      req_valid = 4'b0001;
      req_x     = 16'h0001;
      req_y     = 16'h0001;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      repeat (254) @(posedge clk);
      #1;
      check("sat_254", busy_cnt, 254);
      repeat (7) @(posedge clk);
      #1;
      check("sat_255", busy_cnt, 255);

      // Random traffic against the behavioural model and per-ID scoreboard.
      do_reset();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_id    = 0;
      m_sum   = '0;
      m_busy  = 0;
      pv      = '0;
      for (int i = 0; i < NREQ; i++) begin
         sb[i].delete();
         px[i] = '0;
         py[i] = '0;
      end
      for (int cyc = 0; cyc < 150; cyc++) begin
         bit         gen;
         bit         can;
         int         g;
         logic [3:0] exp_ready;
         gen = (cyc < 110);
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && gen) begin
               pv[i] = ($urandom_range(0, 2) != 0);
               px[i] = 4'($urandom_range(0, 15));
               py[i] = 4'($urandom_range(0, 15));
            end
            req_x[i*4 +: 4] = px[i];
            req_y[i*4 +: 4] = py[i];
         end
         req_valid = pv;
         rsp_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;

         can       = !m_valid || rsp_ready;
         g         = rr_pick(pv, m_ptr);
         exp_ready = (g >= 0 && can) ? (4'b0001 << g) : 4'b0000;

         @(negedge clk);
         check("rnd_ready", req_ready, exp_ready);
         check("rnd_valid", rsp_valid, m_valid);
         if (m_valid) begin
            check("rnd_id",  rsp_id,  m_id);
            check("rnd_sum", rsp_sum, m_sum);
         end
         check("rnd_busy", busy_cnt, m_busy);

         if (rsp_valid && rsp_ready) begin
            if (sb[rsp_id].size() == 0) begin
               check("sb_duplicate", 1, 0);
            end else begin
               check("sb_sum", rsp_sum, sb[rsp_id].pop_front());
            end
         end

         if (pv != 0 && !can && m_busy < 255) m_busy++;
         if (g >= 0 && can) begin
            logic [4:0] s;
            s = 5'(px[g]) + 5'(py[g]);
            sb[g].push_back(s);
            m_valid = 1'b1;
            m_id    = g;
            m_sum   = s;
            m_ptr   = (g + 1) % NREQ;
            pv[g]   = 1'b0;
         end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
         end

         @(posedge clk);
         #1;
      end
      for (int i = 0; i < NREQ; i++) begin
         check($sformatf("sb_empty%0d", i), sb[i].size(), 0);
      end
      check("rnd_final_valid", rsp_valid, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
